mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
- Upstream sequencer and downstream capture stage for the 31-way, 2-bit channel mux.
- Walks the mux select across enabled channels 0..30 and registers each mux result.
- Presents each result as an (index, data) item on a valid/ready stream.
- Used for channel sweeps, readback and self-check of the mux path.

Parameters:
NUM_CH, 31, number of mux channels; legal indices 0..NUM_CH-1
SEL_W, 5, select width
DATA_W, 2, mux data width
PARK_SEL, 31, select value driven when idle; out of range, so the mux returns 0

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST_N  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a sweep when idle
continuous  in  1  sampled at start; 1 = wrap to the first enabled channel after the last
ch_mask  in  NUM_CH  enabled channels; sampled at start, ignored afterwards
abort  in  1  ends the sweep at the next edge
sel  out  SEL_W  registered select to the mux
mux_out  in  DATA_W  combinational mux result for the current sel
o_valid  out  1  output item valid
o_ready  in  1  consumer ready
o_index  out  SEL_W  channel index of the item
o_data  out  DATA_W  captured mux data
o_last  out  1  item is the last enabled channel of this pass
busy  out  1  high from the edge after start until the sweep ends
done  out  1  one-cycle pulse when a non-continuous sweep completes or an abort occurs

Behaviour:
- Reset (RST_N low at an edge): state IDLE, sel=PARK_SEL, o_valid=0, o_index=0, o_data=0, o_last=0, busy=0, done=0, latched mask=0, latched continuous=0.
- States: IDLE, SEL, PRESENT.
- IDLE, start=1:
  - latch ch_mask and continuous; busy<=1.
  - if mask==0: done<=1 for one cycle, stay IDLE, busy<=0, emit no items.
  - else: sel<=lowest set mask bit, go SEL.
- IDLE, start=0: hold; sel stays PARK_SEL.
- SEL (one cycle; the mux settles on the registered sel):
  - o_data<=mux_out, o_index<=sel, o_valid<=1.
  - o_last<=1 if no set mask bit is above sel.
  - go PRESENT.
- PRESENT:
  - Without handshake: hold o_valid, o_index, o_data, o_last and sel stable.
  - On handshake (o_valid & o_ready): o_valid<=0.
    - Next enabled channel above sel exists: sel<=it, go SEL.
    - None and continuous=1: sel<=lowest enabled channel, go SEL.
    - None and continuous=0: sel<=PARK_SEL, busy<=0, done<=1, go IDLE.
- Timing:
  - start sampled at edge k -> o_valid high after edge k+1.
  - Handshake at edge m -> next o_valid after edge m+1.
  - Peak throughput is one item per 2 cycles. o_valid is low for exactly one cycle between items.
- Index ordering: strictly ascending within a pass; indices 0..30 only, never 31.
- abort (any non-IDLE state): at the next edge o_valid<=0, sel<=PARK_SEL, busy<=0, done<=1, go IDLE.
  - abort overrides a same-cycle handshake; that item counts as consumed.
  - abort in IDLE has no effect.
- start while busy: ignored; ch_mask/continuous changes mid-sweep: ignored.
- Reset mid-sweep: immediate return to reset values at that edge; no done pulse.
- Outputs are registered; no combinational path from o_ready to o_valid.

Decomposition:
- Package mux_scan_pkg: NUM_CH, SEL_W, DATA_W, PARK_SEL, state enum (IDLE, SEL, PRESENT).
- Sub-module mux_scan_next: combinational priority finder.
  - Inputs: mask, current index, wrap flag.
  - Outputs: next index, found flag, first index, is_last.
  - Instantiated once.

Test Plan:
- Mux model inp[i]=i%4, ch_mask=all 31 ones, o_ready=1, continuous=0 -> 31 items, index 0..30 ascending, data=i%4; item 12 data 0, item 13 data 1. o_last only on index 30; done pulses once; 62 cycles start-to-done.
- ch_mask bits {3,12,30}, o_ready low 5 cycles per item -> exactly 3 items (3,12,30). Fields held stable while stalled; o_last on 30.
- start with ch_mask=0 -> done after 1 edge, o_valid never high, sel stays 31.
- continuous=1, mask {0,29}, o_ready=1 -> sequence 0,29,0,29,... with o_last on every 29. abort after 5 items -> o_valid low, done high, sel=31 next cycle.
- RST_N low during PRESENT of a 4-channel sweep -> all outputs at reset values next cycle, no done. A second start pulse while busy during a fresh sweep changes nothing.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared sizes, park value and sequencer state encoding for the channel mux scanner.
package mux_scan_pkg;

    localparam int NUM_CH = 31;
    localparam int SEL_W  = 5;
    localparam int DATA_W = 2;

    // Out-of-range select: the mux returns 0 while the scanner is idle.
    localparam logic [SEL_W-1:0] PARK_SEL = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_PRESENT
    } state_t;

endpackage

// File: rtl/mux_scan_next.sv
// Combinational priority finder: lowest enabled channel, next enabled channel
// above the current index (optionally wrapping), and a last-in-pass flag.
module mux_scan_next
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              wrap,
    output logic [SEL_W-1:0]  nxt_idx,
    output logic              found,
    output logic [SEL_W-1:0]  first_idx,
    output logic              is_last
);

    logic [SEL_W-1:0] above_idx;
    logic [SEL_W-1:0] low_idx;
    logic             above_any;
    logic             mask_any;

    // Walk from the top down so the final hit is the lowest qualifying bit.
    always_comb begin
        above_idx = PARK_SEL;
        above_any = 1'b0;
        low_idx   = PARK_SEL;
        mask_any  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx  = SEL_W'(i);
                mask_any = 1'b1;
                if (SEL_W'(i) > cur) begin
                    above_idx = SEL_W'(i);
                    above_any = 1'b1;
                end
            end
        end
    end

    assign first_idx = low_idx;
    assign is_last   = ~above_any;
    assign found     = above_any | (wrap & mask_any);
    assign nxt_idx   = above_any ? above_idx : (wrap ? low_idx : PARK_SEL);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps the mux select over the enabled channels, captures each mux result
// and presents it as an (index, data) item on a valid/ready stream.
module mux_scan_ctrl
    import mux_scan_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              abort,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] mux_out,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [SEL_W-1:0]  o_index,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [NUM_CH-1:0] mask_q;
    logic              cont_q;

    logic [NUM_CH-1:0] scan_mask;
    logic [SEL_W-1:0]  nxt_idx;
    logic [SEL_W-1:0]  first_idx;
    logic              found;
    logic              is_last;
    logic              hs;

    // While idle the finder looks at the live mask so the first channel is
    // ready on the start edge; afterwards only the latched copy matters.
    assign scan_mask = (state == ST_IDLE) ? ch_mask : mask_q;
    assign hs        = o_valid & o_ready;

    mux_scan_next u_next (
        .mask      (scan_mask),
        .cur       (sel),
        .wrap      (cont_q),
        .nxt_idx   (nxt_idx),
        .found     (found),
        .first_idx (first_idx),
        .is_last   (is_last)
    );

    // Sequencer: IDLE -> SEL (mux settles on registered sel) -> PRESENT (hold until taken).
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            sel     <= PARK_SEL;
            o_valid <= 1'b0;
            o_index <= '0;
            o_data  <= '0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE) begin
                // A same-cycle handshake is swallowed: the item counts as consumed.
                o_valid <= 1'b0;
                sel     <= PARK_SEL;
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            mask_q <= ch_mask;
                            cont_q <= continuous;
                            if (ch_mask == '0) begin
                                // Empty sweep: finish immediately, no items.
                                busy <= 1'b0;
                                done <= 1'b1;
                            end else begin
                                busy  <= 1'b1;
                                sel   <= first_idx;
                                state <= ST_SEL;
                            end
                        end
                    end
                    ST_SEL: begin
                        o_data  <= mux_out;
                        o_index <= sel;
                        o_last  <= is_last;
                        o_valid <= 1'b1;
                        state   <= ST_PRESENT;
                    end
                    ST_PRESENT: begin
                        if (hs) begin
                            o_valid <= 1'b0;
                            if (found) begin
                                sel   <= nxt_idx;
                                state <= ST_SEL;
                            end else begin
                                sel   <= PARK_SEL;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized bench for mux_scan_ctrl with a table-driven mux model and an
// ordered-channel reference list built from the requested mask.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              start;
    logic              continuous;
    logic [NUM_CH-1:0] ch_mask;
    logic              abort;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] mux_out;
    logic              o_valid;
    logic              o_ready;
    logic [SEL_W-1:0]  o_index;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              busy;
    logic              done;

    // Mux model: entry 31 stays 0 so the park select reads back 0.
    logic [DATA_W-1:0] tbl [32];

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign mux_out = tbl[sel];

    mux_scan_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .continuous (continuous),
        .ch_mask    (ch_mask),
        .abort      (abort),
        .sel        (sel),
        .mux_out    (mux_out),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_index    (o_index),
        .o_data     (o_data),
        .o_last     (o_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One sweep. stall<0: random ready; stall>=0: ready low that many cycles per item.
    // n_abort>0: abort once that many items are taken (on the handshake, or in the
    // following select cycle when abort_sel is set). exp_cyc>=0: edges start->done.
    task automatic sweep(input logic [NUM_CH-1:0] m, input logic cont, input int stall,
                         input int n_abort, input bit abort_sel, input int exp_cyc);
        int order[$];
        int pos   = 0;
        int got   = 0;
        int stl   = 0;
        int e     = 0;
        bit in_sel = 1'b1;
        bit ended  = 1'b0;
        bit pend   = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (m[i]) order.push_back(i);

        @(negedge CLK);
        start      = 1'b1;
        ch_mask    = m;
        continuous = cont;
        abort      = 1'b0;
        o_ready    = 1'($urandom);
        @(negedge CLK);
        start      = 1'b0;
        ch_mask    = NUM_CH'($urandom);
        continuous = 1'($urandom);
        if (order.size() == 0) ended = 1'b1;

        while (!ended) begin
            if (e > 4000) begin
                chk("timeout", e, 4000);
                break;
            end
            start   = ($urandom_range(0, 3) == 0);
            ch_mask = NUM_CH'($urandom);
            abort   = 1'b0;
            chk("busy", busy, 1);
            chk("done_mid", done, 0);
            if (in_sel) begin
                chk("gap_valid", o_valid, 0);
                chk("sel_next", sel, order[pos]);
                o_ready = 1'($urandom);
                if (pend) begin
                    abort = 1'b1;
                    ended = 1'b1;
                end
                in_sel = 1'b0;
            end else begin
                chk("valid", o_valid, 1);
                chk("index", o_index, order[pos]);
                chk("data", o_data, tbl[order[pos]]);
                chk("last", o_last, (pos == order.size() - 1));
                chk("sel_hold", sel, order[pos]);
                if (stall < 0) o_ready = 1'($urandom);
                else           o_ready = (stl >= stall);
                if (o_ready) begin
                    got++;
                    stl    = 0;
                    pos++;
                    in_sel = 1'b1;
                    if (pos == order.size()) begin
                        if (cont) pos = 0;
                        else      ended = 1'b1;
                    end
                    if (n_abort > 0 && got == n_abort) begin
                        if (abort_sel && !ended) pend = 1'b1;
                        else begin
                            abort = 1'b1;
                            ended = 1'b1;
                        end
                    end
                end else begin
                    stl++;
                end
            end
            @(negedge CLK);
            e++;
        end

        start   = 1'b0;
        abort   = 1'b0;
        o_ready = 1'b0;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", o_valid, 0);
        chk("end_sel", sel, PARK_SEL);
        if (exp_cyc >= 0) chk("start_to_done", e, exp_cyc);
        @(negedge CLK);
        chk("done_pulse", done, 0);
        chk("idle_sel", sel, PARK_SEL);
        chk("idle_valid", o_valid, 0);
    endtask

    task automatic reset_mid();
        logic [NUM_CH-1:0] m;
        m = '0;
        m[2] = 1'b1; m[5] = 1'b1; m[17] = 1'b1; m[28] = 1'b1;
        @(negedge CLK);
        start = 1'b1; ch_mask = m; continuous = 1'b0; o_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        chk("rst_pre_valid", o_valid, 1);
        chk("rst_pre_index", o_index, 2);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("rst_sel", sel, PARK_SEL);
        chk("rst_valid", o_valid, 0);
        chk("rst_index", o_index, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_no_done", done, 0);
            chk("rst_stays_idle", busy, 0);
        end
    endtask

    initial begin
        logic [NUM_CH-1:0] m;
        logic              c;
        int                n_ab;

        RST_N = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        o_ready = 1'b0; ch_mask = '0;
        for (int i = 0; i < 32; i++) tbl[i] = '0;
        repeat (2) @(negedge CLK);
        chk("reset_sel", sel, PARK_SEL);
        chk("reset_valid", o_valid, 0);
        chk("reset_index", o_index, 0);
        chk("reset_data", o_data, 0);
        chk("reset_last", o_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        RST_N = 1'b1;

        // Full sweep, data = index mod 4, always ready.
        for (int i = 0; i < NUM_CH; i++) tbl[i] = DATA_W'(i % 4);
        sweep('1, 1'b0, 0, 0, 1'b0, 62);

        // Sparse mask with five stall cycles per item.
        m = '0; m[3] = 1'b1; m[12] = 1'b1; m[30] = 1'b1;
        sweep(m, 1'b0, 5, 0, 1'b0, -1);

        // Empty mask: done one edge after start.
        sweep('0, 1'b0, 0, 0, 1'b0, 0);

        // Continuous {0,29}, abort on the fifth handshake.
        m = '0; m[0] = 1'b1; m[29] = 1'b1;
        sweep(m, 1'b1, 0, 5, 1'b0, -1);

        reset_mid();

        // Abort while idle does nothing.
        @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("idle_abort_done", done, 0);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_sel", sel, PARK_SEL);

        // Randomized sweeps.
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < NUM_CH; i++) tbl[i] = DATA_W'($urandom);
            m = NUM_CH'($urandom);
            if (t % 3 == 1) m = m & NUM_CH'($urandom) & NUM_CH'($urandom);
            c = 1'($urandom);
            if (c) n_ab = $urandom_range(1, 10);
            else   n_ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            sweep(m, c, -1, n_ab, 1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
